instruction_aligner: RTL and testbench

Fetch-side realigner that turns a stream of 32-bit aligned memory words into a stream of whole instructions. Each instruction is either a 16-bit compressed instruction, handed to the RVC decompressor, or a 32-bit instruction, which may straddle a word boundary. The block sits between instruction memory and the decode stage. It owns the fetch address and handles branch/jump redirects to halfword-aligned targets.

---
 rtl/instruction_aligner_pkg.sv | 13 +
 rtl/instruction_aligner_halfword_buffer.sv | 54 +++++
 rtl/instruction_aligner.sv | 89 ++++++++
 tb/tb_instruction_aligner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_aligner_pkg.sv
// Shared types and helpers for the fetch-side instruction aligner.
// A halfword whose low two bits are not 2'b11 starts an RVC instruction.
package instruction_aligner_pkg;

    typedef logic [15:0] halfword_t;

    localparam logic [1:0] RVC_QUADRANT_32 = 2'b11;

    function automatic logic is_compressed(input halfword_t hw);
        return hw[1:0] != RVC_QUADRANT_32;
    endfunction

endpackage

// File: rtl/instruction_aligner_halfword_buffer.sv
// Four-deep halfword FIFO: up to two pushes and two pops per cycle.
// Entry 0 is always the head; pops shift the storage down.
module halfword_buffer
    import instruction_aligner_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [1:0] push_cnt,
    input  halfword_t  push_hw0,
    input  halfword_t  push_hw1,
    input  logic [1:0] pop_cnt,
    output halfword_t  head0,
    output halfword_t  head1,
    output logic [2:0] count
);

    logic [3:0][15:0] entries_q, entries_d;
    logic [2:0]       count_q, count_d;
    logic [2:0]       base;
    logic [1:0]       base_nxt;

    always_comb begin
        entries_d = entries_q >> {pop_cnt, 4'b0000};
        base      = count_q - {1'b0, pop_cnt};
        base_nxt  = base[1:0] + 2'd1;
        count_d   = base + {1'b0, push_cnt};
        // New halfwords land right after whatever survives the pop.
        if (push_cnt != 2'd0 && base < 3'd4) begin
            entries_d[base[1:0]] = push_hw0;
        end
        if (push_cnt == 2'd2 && base < 3'd3) begin
            entries_d[base_nxt] = push_hw1;
        end
        if (clear) begin
            count_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries_q <= '0;
            count_q   <= 3'd0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

    assign head0 = entries_q[0];
    assign head1 = entries_q[1];
    assign count = count_q;

endmodule

// File: rtl/instruction_aligner.sv
// Realigns aligned 32-bit fetch words into whole 16/32-bit instructions.
// Owns the fetch address, the instruction PC and redirect handling.
module instruction_aligner
    import instruction_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic        instr_compressed,
    output logic [31:0] instr_pc
);

    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] pc_q, pc_d;
    logic        skip_q, skip_d;

    halfword_t   head0, head1, push_hw0;
    logic [2:0]  count;
    logic [1:0]  push_cnt, pop_cnt;
    logic        head_comp, fetch_hs, instr_hs;

    halfword_buffer u_buf (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push_cnt (push_cnt),
        .push_hw0 (push_hw0),
        .push_hw1 (fetch_data[31:16]),
        .pop_cnt  (pop_cnt),
        .head0    (head0),
        .head1    (head1),
        .count    (count)
    );

    always_comb begin
        head_comp        = is_compressed(head0);
        fetch_ready      = (count <= 3'd2) && !flush;
        fetch_hs         = fetch_valid && fetch_ready;
        instr_valid      = head_comp ? (count >= 3'd1) : (count >= 3'd2);
        instr_compressed = head_comp;
        instr_data       = head_comp ? {16'h0000, head0} : {head1, head0};
        instr_pc         = pc_q;
        fetch_addr       = fetch_addr_q;
        instr_hs         = instr_valid && instr_ready && !flush;
        push_cnt         = fetch_hs ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
        push_hw0         = skip_q ? fetch_data[31:16] : fetch_data[15:0];
        pop_cnt          = instr_hs ? (head_comp ? 2'd1 : 2'd2) : 2'd0;

        fetch_addr_d = fetch_addr_q;
        skip_d       = skip_q;
        pc_d         = pc_q;
        if (flush) begin
            fetch_addr_d = flush_pc & 32'hFFFF_FFFC;
            skip_d       = flush_pc[1];
            pc_d         = flush_pc & 32'hFFFF_FFFE;
        end else begin
            if (fetch_hs) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
                skip_d       = 1'b0;
            end
            if (instr_hs) begin
                pc_d = pc_q + (head_comp ? 32'd2 : 32'd4);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            skip_q       <= RESET_PC[1];
            pc_q         <= RESET_PC;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            skip_q       <= skip_d;
            pc_q         <= pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_aligner.sv
// Scoreboard bench for instruction_aligner: fed words and expected
// instructions are queued, then matched as the DUT handshakes.
module tb_instruction_aligner;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        comp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fetch_addr;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_data = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr_data;
    logic        instr_compressed;
    logic [31:0] instr_pc;

    word_t wq[$];
    exp_t  eq[$];
    int    checks = 0;
    int    failures = 0;

    instruction_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_addr       (fetch_addr),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_data       (fetch_data),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_data       (instr_data),
        .instr_compressed (instr_compressed),
        .instr_pc         (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic drive();
        fetch_valid = (wq.size() > 0);
        fetch_data  = (wq.size() > 0) ? wq[0].data : 32'h0;
    endtask

    task automatic push_word(input logic [31:0] a, input logic [31:0] d);
        word_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic expect_i(input logic [31:0] pc, input logic [31:0] d,
                            input logic c);
        exp_t e;
        e.pc   = pc;
        e.data = d;
        e.comp = c;
        eq.push_back(e);
    endtask

    task automatic cycle();
        logic fhs, ihs;
        exp_t e;
        @(negedge clk);
        fhs = fetch_valid && fetch_ready;
        ihs = instr_valid && instr_ready && !flush && !reset;
        if (fhs) check("fetch_addr", fetch_addr, wq[0].addr);
        if (ihs) begin
            if (eq.size() == 0) begin
                check("unexpected_instr", eq.size(), 1);
            end else begin
                e = eq.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr_data", instr_data, e.data);
                check("instr_comp", {31'b0, instr_compressed}, {31'b0, e.comp});
            end
        end
        @(posedge clk);
        #1;
        if (fhs) void'(wq.pop_front());
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        instr_ready = 1'b1;
        wq.delete();
        eq.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic drained(input string tag);
        check({tag, "_exp_left"}, eq.size(), 0);
        check({tag, "_words_left"}, wq.size(), 0);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_valid_held", {31'b0, instr_valid}, 0);
        do_reset();
        check("rst_valid", {31'b0, instr_valid}, 0);
        check("rst_fetch_addr", fetch_addr, 32'h0);
        check("rst_fetch_ready", {31'b0, fetch_ready}, 1);
        check("rst_pc", instr_pc, 32'h0);

        // Two compressed instructions from one word
        push_word(32'h0, 32'h4501_4581);
        expect_i(32'h0, 32'h0000_4581, 1'b1);
        expect_i(32'h2, 32'h0000_4501, 1'b1);
        drive();
        cycle();
        check("t1_latency", {31'b0, instr_valid}, 1);
        run(4);
        drained("t1");

        // Straddling 32-bit instruction
        do_reset();
        push_word(32'h0, 32'h0013_4581);
        push_word(32'h4, 32'h0000_0513);
        expect_i(32'h0, 32'h0000_4581, 1'b1);
        expect_i(32'h2, 32'h0513_0013, 1'b0);
        expect_i(32'h6, 32'h0000_0000, 1'b1);
        drive();
        run(6);
        drained("t2");

        // Flush to a halfword-offset target
        flush = 1'b1;
        flush_pc = 32'h0000_0106;
        #1;
        check("t3_flush_fready", {31'b0, fetch_ready}, 0);
        cycle();
        flush = 1'b0;
        #1;
        check("t3_fetch_addr", fetch_addr, 32'h104);
        check("t3_pc", instr_pc, 32'h106);
        check("t3_empty", {31'b0, instr_valid}, 0);
        push_word(32'h104, 32'h4501_0001);
        expect_i(32'h106, 32'h0000_4501, 1'b1);
        drive();
        cycle();
        check("t3_latency", {31'b0, instr_valid}, 1);
        run(3);
        drained("t3");

        // Backpressure with a full buffer
        do_reset();
        instr_ready = 1'b0;
        push_word(32'h0, 32'h0005_0001);
        push_word(32'h4, 32'h0009_000D);
        push_word(32'h8, 32'h0011_0015);
        expect_i(32'h0, 32'h0000_0001, 1'b1);
        expect_i(32'h2, 32'h0000_0005, 1'b1);
        expect_i(32'h4, 32'h0000_000D, 1'b1);
        expect_i(32'h6, 32'h0000_0009, 1'b1);
        expect_i(32'h8, 32'h0000_0015, 1'b1);
        expect_i(32'hA, 32'h0000_0011, 1'b1);
        drive();
        run(2);
        for (int i = 0; i < 5; i++) begin
            check("t4_fready", {31'b0, fetch_ready}, 0);
            check("t4_valid", {31'b0, instr_valid}, 1);
            check("t4_data", instr_data, 32'h0000_0001);
            check("t4_pc", instr_pc, 32'h0);
            check("t4_faddr", fetch_addr, 32'h8);
            cycle();
        end
        instr_ready = 1'b1;
        run(10);
        drained("t4");

        // Flush coinciding with instruction and fetch handshakes
        do_reset();
        push_word(32'h0, 32'h4501_4581);
        push_word(32'h4, 32'h1111_1111);
        drive();
        cycle();
        check("t5_pre_valid", {31'b0, instr_valid}, 1);
        flush = 1'b1;
        flush_pc = 32'h0000_0201;
        #1;
        check("t5_flush_fready", {31'b0, fetch_ready}, 0);
        cycle();
        flush = 1'b0;
        wq.delete();
        drive();
        #1;
        check("t5_pc", instr_pc, 32'h200);
        check("t5_empty", {31'b0, instr_valid}, 0);
        check("t5_fetch_addr", fetch_addr, 32'h200);
        push_word(32'h200, 32'h0000_0001);
        expect_i(32'h200, 32'h0000_0001, 1'b1);
        expect_i(32'h202, 32'h0000_0000, 1'b1);
        drive();
        run(4);
        drained("t5");

        // Reset asserted while three halfwords are buffered
        do_reset();
        flush = 1'b1;
        flush_pc = 32'h2;
        cycle();
        flush = 1'b0;
        instr_ready = 1'b0;
        push_word(32'h0, 32'h4501_4581);
        push_word(32'h4, 32'h0005_0001);
        drive();
        run(2);
        check("t6_fready", {31'b0, fetch_ready}, 0);
        check("t6_valid", {31'b0, instr_valid}, 1);
        check("t6_head", instr_data, 32'h0000_4501);
        check("t6_pc", instr_pc, 32'h2);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", {31'b0, instr_valid}, 0);
        check("t6_rst_faddr", fetch_addr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wq.delete();
        eq.delete();
        instr_ready = 1'b1;
        drive();
        #1;
        check("t6_rel_fready", {31'b0, fetch_ready}, 1);
        check("t6_rel_pc", instr_pc, 32'h0);
        push_word(32'h0, 32'h4501_4581);
        expect_i(32'h0, 32'h0000_4581, 1'b1);
        expect_i(32'h2, 32'h0000_4501, 1'b1);
        drive();
        run(4);
        drained("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
